// File: rtl/id_ex_forward.sv
// rtl/id_ex_forward.sv - ID/EX pipeline register with operand forwarding and load-use stall
module id_ex_forward #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  // Decode stage
  input  logic              id_valid,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic [RA_W-1:0]   id_rd,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [2:0]        id_alu_ctl,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              flush,
  // Writeback sources for forwarding
  input  logic              exmem_reg_write,
  input  logic [RA_W-1:0]   exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [RA_W-1:0]   memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  // Hazard and execute stage
  output logic              stall,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_ctl,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic [RA_W-1:0]   ex_dest,
  output logic [DATA_W-1:0] ex_store_data
);

  // A bubble carries ADD so the ALU sees a harmless operation; reset uses AND.
  localparam logic [2:0] ALU_CTL_BUBBLE = 3'b010;
  localparam logic [2:0] ALU_CTL_RESET  = 3'b000;

  logic              valid_q,      valid_d;
  logic [RA_W-1:0]   rs_q,         rs_d;
  logic [RA_W-1:0]   rt_q,         rt_d;
  logic [RA_W-1:0]   dest_q,       dest_d;
  logic [DATA_W-1:0] rs_data_q,    rs_data_d;
  logic [DATA_W-1:0] rt_data_q,    rt_data_d;
  logic [DATA_W-1:0] imm_q,        imm_d;
  logic [2:0]        alu_ctl_q,    alu_ctl_d;
  logic              alu_src_q,    alu_src_d;
  logic              reg_write_q,  reg_write_d;
  logic              mem_read_q,   mem_read_d;
  logic              mem_write_q,  mem_write_d;
  logic              mem_to_reg_q, mem_to_reg_d;

  logic              hz;
  logic [DATA_W-1:0] fwd_a;
  logic [DATA_W-1:0] fwd_b;

  // Load-use hazard: a load in EX whose destination is read by the ID instruction.
  always_comb begin
    hz = 1'b0;
    if (valid_q && mem_read_q && (dest_q != '0) && id_valid) begin
      if (dest_q == id_rs) begin
        hz = 1'b1;
      end else if (id_uses_rt && (dest_q == id_rt)) begin
        hz = 1'b1;
      end
    end
  end

  // A flush squashes the stalled instruction anyway, so holding IF/ID would be pointless.
  assign stall = hz & ~flush;

  // Next ID/EX contents: bubble on flush or hazard, otherwise capture decode.
  always_comb begin
    valid_d      = 1'b0;
    rs_d         = '0;
    rt_d         = '0;
    dest_d       = '0;
    rs_data_d    = '0;
    rt_data_d    = '0;
    imm_d        = '0;
    alu_ctl_d    = ALU_CTL_BUBBLE;
    alu_src_d    = 1'b0;
    reg_write_d  = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_to_reg_d = 1'b0;
    if (!flush && !hz) begin
      valid_d      = id_valid;
      rs_d         = id_rs;
      rt_d         = id_rt;
      dest_d       = id_reg_dst ? id_rd : id_rt;
      rs_data_d    = id_rs_data;
      rt_data_d    = id_rt_data;
      imm_d        = id_imm;
      alu_ctl_d    = id_alu_ctl;
      alu_src_d    = id_alu_src;
      reg_write_d  = id_reg_write;
      mem_read_d   = id_mem_read;
      mem_write_d  = id_mem_write;
      mem_to_reg_d = id_mem_to_reg;
    end
  end

  // ID/EX register with asynchronous reset to the bubble state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      rs_q         <= '0;
      rt_q         <= '0;
      dest_q       <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      alu_ctl_q    <= ALU_CTL_RESET;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      dest_q       <= dest_d;
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_q        <= imm_d;
      alu_ctl_q    <= alu_ctl_d;
      alu_src_q    <= alu_src_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
    end
  end

  // Operand A forwarding: the younger EX/MEM result beats MEM/WB; r0 never forwards.
  always_comb begin
    fwd_a = rs_data_q;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs_q)) begin
      fwd_a = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_q)) begin
      fwd_a = memwb_result;
    end
  end

  // Operand B forwarding, same priority; also feeds store data.
  always_comb begin
    fwd_b = rt_data_q;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rt_q)) begin
      fwd_b = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rt_q)) begin
      fwd_b = memwb_result;
    end
  end

  assign alu_a         = fwd_a;
  assign alu_b         = alu_src_q ? imm_q : fwd_b;
  assign ex_store_data = fwd_b;
  assign alu_ctl       = alu_ctl_q;
  assign ex_valid      = valid_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_mem_to_reg = mem_to_reg_q;
  assign ex_dest       = dest_q;

endmodule

// File: tb/tb_id_ex_forward.sv
// tb/tb_id_ex_forward.sv - scoreboard bench for id_ex_forward
module tb_id_ex_forward;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rt;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [2:0]  id_alu_ctl;
  logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        flush;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        stall;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [2:0]  alu_ctl;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [4:0]  ex_dest;

  id_ex_forward #(.DATA_W(32), .RA_W(5)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_alu_ctl(id_alu_ctl), .id_alu_src(id_alu_src),
    .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .stall(stall), .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_dest(ex_dest),
    .ex_store_data(ex_store_data)
  );

  always #5 clk = ~clk;

  // Output selectors used by the scoreboard
  localparam int S_STALL = 0, S_A = 1, S_B = 2, S_CTL = 3, S_VALID = 4, S_RW = 5;
  localparam int S_MR = 6, S_MW = 7, S_M2R = 8, S_DEST = 9, S_SD = 10;

  string       name_q[$];
  int          sel_q[$];
  logic [31:0] exp_q[$];
  event        sample;
  int          n_pass = 0;
  int          n_total = 0;

  function automatic logic [31:0] dut_val(input int sel);
    case (sel)
      S_STALL: return {31'd0, stall};
      S_A:     return alu_a;
      S_B:     return alu_b;
      S_CTL:   return {29'd0, alu_ctl};
      S_VALID: return {31'd0, ex_valid};
      S_RW:    return {31'd0, ex_reg_write};
      S_MR:    return {31'd0, ex_mem_read};
      S_MW:    return {31'd0, ex_mem_write};
      S_M2R:   return {31'd0, ex_mem_to_reg};
      S_DEST:  return {27'd0, ex_dest};
      default: return ex_store_data;
    endcase
  endfunction

  // Monitor: whenever outputs are presented for sampling, drain and compare expectations.
  initial begin
    forever begin
      @(sample);
      while (sel_q.size() > 0) begin
        string       nm;
        int          sl;
        logic [31:0] ex;
        logic [31:0] got;
        nm  = name_q.pop_front();
        sl  = sel_q.pop_front();
        ex  = exp_q.pop_front();
        got = dut_val(sl);
        n_total++;
        if (got === ex) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, ex);
      end
    end
  end

  task automatic expect_v(input string nm, input int sel, input logic [31:0] ex);
    name_q.push_back(nm);
    sel_q.push_back(sel);
    exp_q.push_back(ex);
  endtask

  task automatic present();
    #1;
    ->sample;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic id_clear();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rt = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_alu_ctl = 3'b010;
    id_alu_src = 0; id_reg_dst = 0; id_reg_write = 0; id_mem_read = 0;
    id_mem_write = 0; id_mem_to_reg = 0;
  endtask

  task automatic id_lw_r4();
    id_clear();
    id_valid = 1; id_rs = 1; id_rs_data = 32'h100; id_rt = 4; id_imm = 32'h4;
    id_alu_src = 1; id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1;
  endtask

  task automatic id_sub_r5_r4_r6();
    id_clear();
    id_valid = 1; id_rs = 4; id_rt = 6; id_rd = 5; id_reg_dst = 1; id_uses_rt = 1;
    id_alu_ctl = 3'b110; id_reg_write = 1; id_rs_data = 32'hDEAD; id_rt_data = 32'h3;
  endtask

  initial begin
    rst = 1; flush = 0;
    id_clear();
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    step(); step();
    expect_v("reset_valid", S_VALID, 0);
    expect_v("reset_ctl", S_CTL, 3'b000);
    expect_v("reset_stall", S_STALL, 0);
    expect_v("reset_alu_a", S_A, 0);
    present();

    // add r8, r3, r7
    id_valid = 1; id_rs = 3; id_rt = 7; id_rd = 8; id_reg_dst = 1; id_uses_rt = 1;
    id_rs_data = 32'h5; id_rt_data = 32'h11; id_alu_ctl = 3'b010; id_reg_write = 1;
    rst = 0;
    step();
    exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'h10;
    expect_v("exmem_fwd_a", S_A, 32'h10);
    expect_v("no_fwd_b", S_B, 32'h11);
    expect_v("add_dest_rd", S_DEST, 8);
    expect_v("add_valid", S_VALID, 1);
    present();
    memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'h20;
    expect_v("exmem_priority", S_A, 32'h10);
    present();
    exmem_reg_write = 0;
    expect_v("memwb_fwd_a", S_A, 32'h20);
    present();
    memwb_reg_write = 0;
    expect_v("reg_data_a", S_A, 32'h5);
    present();

    // r0 guard: or r9, r0, r0
    id_clear();
    id_valid = 1; id_rd = 9; id_reg_dst = 1; id_alu_ctl = 3'b001; id_uses_rt = 1;
    step();
    exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hFFFF_FFFF;
    memwb_reg_write = 1; memwb_rd = 0; memwb_result = 32'h1234;
    expect_v("r0_guard_a", S_A, 0);
    expect_v("r0_guard_b", S_B, 0);
    expect_v("or_ctl", S_CTL, 3'b001);
    present();
    exmem_reg_write = 0; memwb_reg_write = 0;

    // Load-use: lw r4 then sub r5, r4, r6
    id_lw_r4();
    step();
    expect_v("lw_mem_read", S_MR, 1);
    expect_v("lw_dest_rt", S_DEST, 4);
    expect_v("lw_imm_b", S_B, 32'h4);
    id_sub_r5_r4_r6();
    expect_v("load_use_stall", S_STALL, 1);
    present();
    step();
    expect_v("bubble_valid", S_VALID, 0);
    expect_v("bubble_rw", S_RW, 0);
    expect_v("bubble_ctl", S_CTL, 3'b010);
    expect_v("stall_one_cycle", S_STALL, 0);
    present();
    step();
    memwb_reg_write = 1; memwb_rd = 4; memwb_result = 32'h7;
    expect_v("sub_memwb_a", S_A, 32'h7);
    expect_v("sub_ctl", S_CTL, 3'b110);
    expect_v("sub_b", S_B, 32'h3);
    expect_v("sub_dest", S_DEST, 5);
    expect_v("sub_valid", S_VALID, 1);
    present();
    memwb_reg_write = 0;

    // Hazard variants against a load in EX, then flush over hazard
    id_lw_r4();
    step();
    id_clear();
    id_valid = 1; id_rs = 1; id_rt = 4; id_uses_rt = 1;
    expect_v("hz_via_rt", S_STALL, 1);
    present();
    id_uses_rt = 0;
    expect_v("no_hz_rt_unused", S_STALL, 0);
    present();
    id_sub_r5_r4_r6();
    id_valid = 0;
    expect_v("no_hz_invalid_id", S_STALL, 0);
    present();
    id_valid = 1; flush = 1;
    expect_v("flush_kills_stall", S_STALL, 0);
    present();
    step();
    flush = 0;
    expect_v("flush_valid", S_VALID, 0);
    expect_v("flush_rw", S_RW, 0);
    expect_v("flush_ctl", S_CTL, 3'b010);
    present();

    // sw r2, 8(r1)
    id_clear();
    id_valid = 1; id_rs = 1; id_rs_data = 32'h200; id_rt = 2; id_rt_data = 32'h55;
    id_uses_rt = 1; id_imm = 32'h8; id_alu_src = 1; id_mem_write = 1;
    step();
    exmem_reg_write = 1; exmem_rd = 2; exmem_result = 32'hABCD;
    expect_v("sw_alu_b_imm", S_B, 32'h8);
    expect_v("sw_store_fwd", S_SD, 32'hABCD);
    expect_v("sw_mem_write", S_MW, 1);
    expect_v("sw_alu_a", S_A, 32'h200);
    present();
    exmem_reg_write = 0;

    // id_valid=0 still captures control as presented
    id_clear();
    id_reg_write = 1; id_mem_to_reg = 1; id_alu_ctl = 3'b111;
    step();
    expect_v("inval_valid", S_VALID, 0);
    expect_v("inval_rw", S_RW, 1);
    expect_v("inval_m2r", S_M2R, 1);
    expect_v("inval_ctl", S_CTL, 3'b111);
    present();

    // Asynchronous reset mid-cycle with registers loaded
    #1;
    rst = 1;
    expect_v("async_rst_rw", S_RW, 0);
    expect_v("async_rst_m2r", S_M2R, 0);
    expect_v("async_rst_ctl", S_CTL, 3'b000);
    expect_v("async_rst_stall", S_STALL, 0);
    expect_v("async_rst_b", S_B, 0);
    present();

    // First capture after reset release
    id_clear();
    id_valid = 1; id_rs = 2; id_rs_data = 32'h9; id_rt = 6; id_alu_ctl = 3'b110;
    step();
    rst = 0;
    step();
    expect_v("post_rst_valid", S_VALID, 1);
    expect_v("post_rst_a", S_A, 32'h9);
    expect_v("post_rst_dest", S_DEST, 6);
    present();

    if (sel_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sel_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_ex_forward.md
# id_ex_forward

Pipeline register between decode (ID) and execute (EX) of the 5-stage CPU, combined with the operand-forwarding network and load-use hazard detection. Captures decoded operands and control each cycle and drives the ALU operands (`alu_a`, `alu_b`) and the 3-bit ALU control directly. Also issues the stall that freezes PC and IF/ID on a load-use dependency. Squashes its contents into a bubble on a taken-branch flush.

## Interface
- `DATA_W`, 32: datapath width.
- `RA_W`, 5: register-address width. Register 0 is hard-wired zero.

- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs`, `id_rt`, `id_rd` in RA_W each: source and destination register fields.
- `id_uses_rt` in 1: the instruction reads rt (R-type or store).
- `id_rs_data`, `id_rt_data` in DATA_W each: register-file read data.
- `id_imm` in DATA_W: sign-extended immediate.
- `id_alu_ctl` in 3: ALU operation.
  - Encodings: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- `id_alu_src` in 1: 1 selects `id_imm` as operand B.
- `id_reg_dst` in 1: 1 selects rd as destination, 0 selects rt.
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_mem_to_reg` in 1 each: control bits.
- `flush` in 1: taken branch; squash the instruction entering EX.
- `exmem_reg_write` in 1, `exmem_rd` in RA_W, `exmem_result` in DATA_W: EX/MEM writeback info.
- `memwb_reg_write` in 1, `memwb_rd` in RA_W, `memwb_result` in DATA_W: MEM/WB writeback info.
- `stall` out 1: hold PC and IF/ID.
- `alu_a`, `alu_b` out DATA_W each: ALU operands.
- `alu_ctl` out 3: ALU control.
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_mem_to_reg` out 1 each: EX-stage control.
- `ex_dest` out RA_W: resolved destination register.
- `ex_store_data` out DATA_W: forwarded rt value for stores.

## Operation
- Registered state (ID/EX): valid, rs, rt, dest, rs_data, rt_data, imm, alu_ctl, alu_src, reg_write, mem_read, mem_write, mem_to_reg.
- `dest` is computed at capture: `id_reg_dst ? id_rd : id_rt`.
- Load-use hazard, combinational. `hz` is asserted when all of the following hold:
  - `ex_valid & ex_mem_read & ex_dest != 0 & id_valid`
  - and either `ex_dest == id_rs`, or `id_uses_rt & ex_dest == id_rt`.
- `stall = hz & ~flush`.
- Register update on each rising edge, in priority order:
  - `flush`: load a bubble.
  - else `hz`: load a bubble.
  - else: capture all ID inputs, with valid = `id_valid`.
- Bubble contents: valid=0; reg_write, mem_read, mem_write, mem_to_reg = 0; alu_ctl=010; alu_src=0; rs=rt=dest=0; data fields = 0.
- Forwarding is combinational from the registered rs and rt, computed separately for each operand (fwdA, fwdB):
  - If `exmem_reg_write & exmem_rd != 0 & exmem_rd == r`: use `exmem_result`. This source has priority.
  - Else if `memwb_reg_write & memwb_rd != 0 & memwb_rd == r`: use `memwb_result`.
  - Else: use the registered data.
- Outputs:
  - `alu_a = fwdA`.
  - `alu_b = alu_src ? imm : fwdB`.
  - `ex_store_data = fwdB`, regardless of alu_src.
  - `alu_ctl` and all `ex_*` outputs come directly from the registers.
- Register 0 is never forwarded. A source of 0 always yields the registered data, which is 0 by register-file contract.

## Timing
- Reset value of every registered field is the bubble value, except alu_ctl, which resets to 000.
  - During and after reset: `ex_valid`=0, `ex_dest`=0, all `ex_*` controls 0, `alu_a`=`alu_b`=`ex_store_data`=0, `stall`=0.
- Reset is asynchronous and takes effect immediately mid-operation, with no clock required. The first capture happens on the first rising edge after `rst` deasserts.
- ID→EX latency is 1 cycle. Forwarding muxes add 0 cycles; operands are valid in the same cycle the EX/MEM and MEM/WB inputs are.
- Stall lasts exactly 1 cycle per load-use pair. After the bubble, the load sits in MEM/WB and its result is forwarded through the MEM/WB path.
- `flush` and `hz` in the same cycle: flush wins, `stall`=0, a bubble is loaded.
- `id_valid`=0: the captured valid=0; control bits are captured as presented. No stall is raised.
- `stall` is purely combinational. It depends on current ID inputs and registered EX state, with no dependence on EX/MEM or MEM/WB.

## Test plan
- Reset: assert `rst` mid-stream with the registers loaded → outputs go to 0 immediately, with no clock edge. `alu_ctl`=000, `stall`=0.
- EX/MEM forward:
  - Setup: `add r3` in EX/MEM with `exmem_result`=0x0000_0010; the instruction in EX has rs=3, registered rs_data=0x5.
  - Required: `alu_a`=0x10.
  - Also present `memwb_rd`=3, `memwb_result`=0x20 in the same cycle → `alu_a` stays 0x10 (EX/MEM priority).
- r0 guard: `exmem_rd`=0, `exmem_reg_write`=1, `exmem_result`=0xFFFF_FFFF; EX has rs=0 → `alu_a`=0.
- Load-use:
  - Setup: `lw r4` in EX (mem_read=1, dest=4); ID presents `sub r5,r4,r6` (rs=4, alu_ctl=110).
  - Required: `stall`=1 for one cycle, and the next EX contents are a bubble (`ex_valid`=0).
  - One cycle later, `sub` enters EX with `memwb_rd`=4, `memwb_result`=0x7 → `alu_a`=0x7, `alu_ctl`=110.
- Flush over hazard: same setup as the load-use scenario, with `flush`=1 → `stall`=0; next cycle `ex_valid`=0, `ex_reg_write`=0, `alu_ctl`=010.
- Immediate and store:
  - Setup: `sw` with alu_src=1, imm=0x8, rt=2; `exmem_rd`=2, `exmem_result`=0xABCD.
  - Required: `alu_b`=0x8, `ex_store_data`=0xABCD, `ex_mem_write`=1.
